// File: rtl/vga_vram_arbiter.sv
// vga_vram_arbiter: shares one single-port synchronous VRAM between the VGA
// display fetch unit and the CPU bus port. One access per cycle, read data is
// routed back to its issuer via a two-stage tag pipeline, and the CPU has a
// bounded wait even under continuous display traffic.
module vga_vram_arbiter #(
    parameter int AW         = 15,
    parameter int DW         = 8,
    parameter int STARVE_MAX = 8
) (
    input  logic          mclk,
    input  logic          rst_n,
    input  logic          blank,
    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic          disp_gnt,
    output logic          disp_rvalid,
    output logic [DW-1:0] disp_rdata,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    logic [7:0] cpu_wait_r;
    logic       cpu_win_s;
    logic       disp_win_s;
    logic       tag1_valid_r;
    logic       tag1_cpu_r;
    logic       disp_rv_r;
    logic       cpu_rv_r;

    // Priority arbiter: starved CPU, then CPU during blanking, then display, then CPU.
    always_comb begin
        cpu_win_s  = 1'b0;
        disp_win_s = 1'b0;
        if (!rst_n) begin
            cpu_win_s  = 1'b0;
            disp_win_s = 1'b0;
        end else if (cpu_req && (cpu_wait_r == STARVE_LIM)) begin
            cpu_win_s = 1'b1;
        end else if (cpu_req && blank) begin
            cpu_win_s = 1'b1;
        end else if (disp_req) begin
            disp_win_s = 1'b1;
        end else if (cpu_req) begin
            cpu_win_s = 1'b1;
        end else begin
            cpu_win_s  = 1'b0;
            disp_win_s = 1'b0;
        end
    end

    assign cpu_gnt    = cpu_win_s;
    assign disp_gnt   = disp_win_s;
    assign disp_rdata = ram_rdata;
    assign cpu_rdata  = ram_rdata;
    assign disp_rvalid = disp_rv_r;
    assign cpu_rvalid  = cpu_rv_r;

    // Counts consecutive denied CPU cycles, saturating at the starvation limit.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_wait_r <= 8'd0;
        end else if (!cpu_req || cpu_win_s) begin
            cpu_wait_r <= 8'd0;
        end else if (cpu_wait_r != STARVE_LIM) begin
            cpu_wait_r <= cpu_wait_r + 8'd1;
        end else begin
            cpu_wait_r <= cpu_wait_r;
        end
    end

    // Registers the winner's access onto the RAM port; address/data hold when idle.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else if (cpu_win_s) begin
            ram_en    <= 1'b1;
            ram_we    <= cpu_we;
            ram_addr  <= cpu_addr;
            ram_wdata <= cpu_wdata;
        end else if (disp_win_s) begin
            ram_en    <= 1'b1;
            ram_we    <= 1'b0;
            ram_addr  <= disp_addr;
        end else begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
        end
    end

    // Read tag pipeline: stage 1 rides with ram_en, stage 2 with ram_rdata.
    // Stage 2 is stored already split by owner so the rvalid outputs are flops.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            tag1_valid_r <= 1'b0;
            tag1_cpu_r   <= 1'b0;
            disp_rv_r    <= 1'b0;
            cpu_rv_r     <= 1'b0;
        end else begin
            tag1_valid_r <= disp_win_s | (cpu_win_s & ~cpu_we);
            tag1_cpu_r   <= cpu_win_s;
            disp_rv_r    <= tag1_valid_r & ~tag1_cpu_r;
            cpu_rv_r     <= tag1_valid_r & tag1_cpu_r;
        end
    end

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Self-checking bench for vga_vram_arbiter: behavioural RAM, reference memory
// and per-requester scoreboards of expected read data and arrival cycle.
module tb_vga_vram_arbiter;

    localparam int AW = 15;
    localparam int DW = 8;

    logic          mclk = 1'b0;
    logic          rst_n;
    logic          blank;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          disp_gnt;
    logic          disp_rvalid;
    logic [DW-1:0] disp_rdata;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          disp_q[$];
    exp_t          cpu_q[$];
    logic [DW-1:0] mem     [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            cyc = 0;
    int            total = 0;
    int            bad = 0;
    int            disp_rv_cnt = 0;
    int            cpu_rv_cnt = 0;

    vga_vram_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(8)) dut (
        .mclk(mclk), .rst_n(rst_n), .blank(blank),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
        .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .cpu_rdata(cpu_rdata), .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 mclk = ~mclk;

    always @(posedge mclk) cyc <= cyc + 1;

    // Behavioural single-port synchronous RAM.
    always @(posedge mclk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    // Scoreboard: push expectations on grants, pop and compare on rvalid.
    always @(negedge mclk) begin
        exp_t e;
        if (rst_n) begin
            if (disp_gnt && cpu_gnt) begin
                total = total + 1;
                bad = bad + 1;
                $display("FAIL dual_grant cyc=%0d disp_gnt=1 cpu_gnt=1 required one at most", cyc);
            end
            if (disp_gnt) disp_q.push_back('{cyc + 2, ref_mem[disp_addr]});
            if (cpu_gnt) begin
                if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
                else        cpu_q.push_back('{cyc + 2, ref_mem[cpu_addr]});
            end
        end
        if (disp_rvalid) begin
            disp_rv_cnt = disp_rv_cnt + 1;
            total = total + 1;
            if (disp_q.size() == 0) begin
                bad = bad + 1;
                $display("FAIL disp_unexpected_rvalid cyc=%0d data=%02h required no rvalid", cyc, disp_rdata);
            end else begin
                e = disp_q.pop_front();
                if (e.cyc !== cyc || e.data !== disp_rdata) begin
                    bad = bad + 1;
                    $display("FAIL disp_read cyc=%0d data=%02h required cyc=%0d data=%02h", cyc, disp_rdata, e.cyc, e.data);
                end
            end
        end
        if (cpu_rvalid) begin
            cpu_rv_cnt = cpu_rv_cnt + 1;
            total = total + 1;
            if (cpu_q.size() == 0) begin
                bad = bad + 1;
                $display("FAIL cpu_unexpected_rvalid cyc=%0d data=%02h required no rvalid", cyc, cpu_rdata);
            end else begin
                e = cpu_q.pop_front();
                if (e.cyc !== cyc || e.data !== cpu_rdata) begin
                    bad = bad + 1;
                    $display("FAIL cpu_read cyc=%0d data=%02h required cyc=%0d data=%02h", cyc, cpu_rdata, e.cyc, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge mclk);
        #2;
    endtask

    task automatic idle_inputs();
        blank = 1'b0; disp_req = 1'b0; disp_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 4; i++) tick();
        total = total + 1;
        if (disp_q.size() != 0 || cpu_q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL %s_pending disp_q=%0d cpu_q=%0d required 0 0", name, disp_q.size(), cpu_q.size());
            disp_q.delete();
            cpu_q.delete();
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge mclk);
            total = total + 1;
            if ({ram_en, ram_we, ram_addr, ram_wdata, disp_gnt, cpu_gnt, disp_rvalid, cpu_rvalid} !== '0) begin
                bad = bad + 1;
                $display("FAIL reset_outputs en=%b we=%b addr=%h wdata=%h gnt=%b%b rv=%b%b required all 0",
                         ram_en, ram_we, ram_addr, ram_wdata, disp_gnt, cpu_gnt, disp_rvalid, cpu_rvalid);
            end
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge mclk);
            total = total + 1;
            if ({ram_en, ram_we, disp_gnt, cpu_gnt, disp_rvalid, cpu_rvalid} !== 6'b0) begin
                bad = bad + 1;
                $display("FAIL idle_after_reset i=%0d en=%b we=%b gnt=%b%b rv=%b%b required all 0",
                         i, ram_en, ram_we, disp_gnt, cpu_gnt, disp_rvalid, cpu_rvalid);
            end
            tick();
        end
    endtask

    task automatic test_disp_stream();
        int start_cnt = disp_rv_cnt;
        for (int i = 0; i < 8; i++) begin
            disp_req = 1'b1;
            disp_addr = 15'h0100 + 15'(i);
            @(negedge mclk);
            total = total + 1;
            if (disp_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin
                bad = bad + 1;
                $display("FAIL disp_stream_gnt i=%0d disp_gnt=%b cpu_gnt=%b required 1 0", i, disp_gnt, cpu_gnt);
            end
            tick();
        end
        disp_req = 1'b0;
        drain("disp_stream");
        total = total + 1;
        if (disp_rv_cnt - start_cnt != 8) begin
            bad = bad + 1;
            $display("FAIL disp_stream_count got=%0d required 8", disp_rv_cnt - start_cnt);
        end
    endtask

    task automatic test_starvation();
        int start_cnt = cpu_rv_cnt;
        blank = 1'b0;
        disp_req = 1'b1; disp_addr = 15'h0200;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h1234;
        for (int k = 0; k <= 8; k++) begin
            @(negedge mclk);
            total = total + 1;
            if (cpu_gnt !== (k == 8) || disp_gnt !== (k != 8)) begin
                bad = bad + 1;
                $display("FAIL starve_gnt k=%0d cpu_gnt=%b disp_gnt=%b required %b %b",
                         k, cpu_gnt, disp_gnt, (k == 8), (k != 8));
            end
            tick();
        end
        cpu_req = 1'b0;
        tick();
        disp_req = 1'b0;
        drain("starve");
        total = total + 1;
        if (cpu_rv_cnt - start_cnt != 1) begin
            bad = bad + 1;
            $display("FAIL starve_cpu_rvalid_count got=%0d required 1", cpu_rv_cnt - start_cnt);
        end
    endtask

    task automatic test_blank_priority();
        for (int b = 1; b >= 0; b--) begin
            blank = b[0];
            disp_req = 1'b1; disp_addr = 15'h0301;
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0300;
            @(negedge mclk);
            total = total + 1;
            if (cpu_gnt !== b[0] || disp_gnt !== ~b[0]) begin
                bad = bad + 1;
                $display("FAIL blank%0d_first cpu_gnt=%b disp_gnt=%b required %b %b", b, cpu_gnt, disp_gnt, b[0], ~b[0]);
            end
            tick();
            if (b == 1) cpu_req = 1'b0;
            else        disp_req = 1'b0;
            @(negedge mclk);
            total = total + 1;
            if (cpu_gnt !== ~b[0] || disp_gnt !== b[0]) begin
                bad = bad + 1;
                $display("FAIL blank%0d_second cpu_gnt=%b disp_gnt=%b required %b %b", b, cpu_gnt, disp_gnt, ~b[0], b[0]);
            end
            tick();
            idle_inputs();
            drain("blank_priority");
        end
    endtask

    task automatic test_write_read();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0042; cpu_wdata = 8'hA5;
        @(negedge mclk);
        total = total + 1;
        if (cpu_gnt !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL wr_gnt cpu_gnt=%b required 1", cpu_gnt);
        end
        tick();
        cpu_we = 1'b0; cpu_wdata = 8'h00;
        @(negedge mclk);
        total = total + 1;
        if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 15'h0042 || ram_wdata !== 8'hA5 || cpu_gnt !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL wr_ram_port en=%b we=%b addr=%h wdata=%h gnt=%b required 1 1 0042 a5 1",
                     ram_en, ram_we, ram_addr, ram_wdata, cpu_gnt);
        end
        tick();
        cpu_req = 1'b0;
        @(negedge mclk);
        total = total + 1;
        if (cpu_rvalid !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL wr_no_rvalid cpu_rvalid=%b required 0", cpu_rvalid);
        end
        tick();
        @(negedge mclk);
        total = total + 1;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'hA5) begin
            bad = bad + 1;
            $display("FAIL raw_read cpu_rvalid=%b cpu_rdata=%02h required 1 a5", cpu_rvalid, cpu_rdata);
        end
        tick();
        drain("write_read");
    endtask

    task automatic test_reset_mid_read();
        int start_cnt = disp_rv_cnt;
        disp_req = 1'b1; disp_addr = 15'h0105;
        @(negedge mclk);
        total = total + 1;
        if (disp_gnt !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL midrd_gnt disp_gnt=%b required 1", disp_gnt);
        end
        tick();
        disp_req = 1'b0;
        rst_n = 1'b0;
        disp_q.delete();
        for (int i = 0; i < 2; i++) begin
            @(negedge mclk);
            total = total + 1;
            if ({ram_en, ram_we, ram_addr, ram_wdata, disp_gnt, cpu_gnt, disp_rvalid} !== '0) begin
                bad = bad + 1;
                $display("FAIL midrd_reset_outputs en=%b we=%b addr=%h wdata=%h gnt=%b%b rv=%b required all 0",
                         ram_en, ram_we, ram_addr, ram_wdata, disp_gnt, cpu_gnt, disp_rvalid);
            end
            tick();
        end
        rst_n = 1'b1;
        drain("reset_mid_read");
        total = total + 1;
        if (disp_rv_cnt != start_cnt) begin
            bad = bad + 1;
            $display("FAIL midrd_rvalid_seen count=%0d required 0", disp_rv_cnt - start_cnt);
        end
    endtask

    initial begin
        for (int a = 0; a < (1 << AW); a++) begin
            mem[a]     = 8'(a);
            ref_mem[a] = 8'(a);
        end
        idle_inputs();
        rst_n = 1'b0;
        tick();
        test_reset();
        test_disp_stream();
        test_starvation();
        test_blank_priority();
        test_write_read();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d required completion", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vga_vram_arbiter.md
# vga_vram_arbiter

Shares one single-port synchronous video RAM between two requesters: the VGA display fetch unit, which must refill its line buffer during active video, and the CPU bus port, which reads and writes framebuffer bytes. The block sits between the VGA timing/fetch logic and the VRAM. It issues at most one RAM access per `mclk` cycle and routes read data back to the requester that issued it. It guarantees the CPU a bounded wait even while the display requests continuously.

## Interface
Parameters:
- `AW`, 15, VRAM address width.
- `DW`, 8, VRAM data width (one pixel, RRRGGGBB).
- `STARVE_MAX`, 8, consecutive denied CPU cycles before the CPU is forced to win. Legal range is 1..255.

Ports:
- Clocking and reset: one clock, `mclk`; reset `rst_n` is asynchronous and active-low.
- `mclk`  in  1  system clock (50 MHz).
- `rst_n`  in  1  asynchronous active-low reset.
- `blank`  in  1  high while VGA timing is outside the active area; the CPU gets priority.
- `disp_req`  in  1  display read request; held until granted.
- `disp_addr`  in  AW  display read address; stable while `disp_req` is high.
- `disp_gnt`  out  1  display request accepted this cycle (combinational).
- `disp_rvalid`  out  1  `disp_rdata` is valid this cycle.
- `disp_rdata`  out  DW  display read data.
- `cpu_req`  in  1  CPU request; held until granted.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  AW  CPU address.
- `cpu_wdata`  in  DW  CPU write data.
- `cpu_gnt`  out  1  CPU request accepted this cycle (combinational).
- `cpu_rvalid`  out  1  `cpu_rdata` is valid (reads only).
- `cpu_rdata`  out  DW  CPU read data.
- `ram_en`, `ram_we`  out  1  registered RAM enable and write enable.
- `ram_addr`  out  AW  registered RAM address.
- `ram_wdata`  out  DW  registered RAM write data.
- `ram_rdata`  in  DW  RAM read data, valid one cycle after `ram_en` with `ram_we`=0.

## Operation
- Arbitration runs every cycle. The winner is decided combinationally from `disp_req`, `cpu_req`, `blank` and `cpu_wait`.
- Priority order, first match wins:
  1. CPU wins if `cpu_req` and `cpu_wait == STARVE_MAX`.
  2. CPU wins if `cpu_req` and `blank`.
  3. Display wins if `disp_req`.
  4. CPU wins if `cpu_req`.
  5. Otherwise the cycle is idle.
- Only the winner sees its `*_gnt`=1. `disp_gnt` and `cpu_gnt` are never high together.
- A requester may change address/data or drop its request on the edge that ends its grant cycle.
- `cpu_wait`, an 8-bit counter:
  - Cleared when `cpu_req`=0 or `cpu_gnt`=1.
  - Otherwise increments, saturating at `STARVE_MAX`.
- On a grant, the winner's address, write enable and write data are registered onto `ram_*` with `ram_en`=1. A cycle without a grant registers `ram_en`=0 and `ram_we`=0; `ram_addr` and `ram_wdata` hold their last values.
- A 2-stage tag pipeline tracks each read: {valid, owner}. Stage 1 is aligned with `ram_en`; stage 2 is aligned with `ram_rdata`.
  - `disp_rvalid` = stage 2 valid AND owner = display.
  - `cpu_rvalid` = stage 2 valid AND owner = CPU.
  - CPU writes never create a tag.
- `disp_rdata` and `cpu_rdata` both pass `ram_rdata` straight through. They are meaningful only while the matching `rvalid` is high.
- Reset, asynchronous assert:
  - `ram_en`, `ram_we`, `ram_addr`, `ram_wdata`, tag pipeline, `cpu_wait`, `disp_rvalid` and `cpu_rvalid` all go to 0.
  - `disp_gnt` and `cpu_gnt` are forced to 0 while `rst_n`=0.
  - A read in flight at reset is discarded; its `rvalid` never appears.

## Timing
- Grant at cycle N → `ram_en` high in N+1 → `ram_rdata` and `*_rvalid` high in N+2. Read latency from grant is exactly 2 cycles.
- A CPU write lands in RAM at the end of cycle N+1.
- Throughput is one access per cycle. Back-to-back grants to the same requester are allowed, and rvalid pulses are then back-to-back.
- Worst-case CPU wait with display continuously requesting and `blank`=0 is `STARVE_MAX` cycles. The grant comes in the cycle where `cpu_wait` equals `STARVE_MAX`.
- Simultaneous requests in the same cycle follow the priority list; the loser keeps its request and is re-evaluated next cycle.
- A read-after-write to the same address from the CPU returns the new data. The write occupies RAM in N+1; the read is granted no earlier than N+1 and accesses RAM no earlier than N+2.
- The `blank` transition takes effect on the same cycle it changes; it is not registered.

## Test plan
- **Idle after reset:** hold `rst_n`=0 for 3 cycles, then release with no requests. Expect all outputs 0, and `ram_en` to stay 0 for 10 cycles.
- **Display stream:** `disp_req`=1 for addresses 0x0100..0x0107 with `blank`=0, RAM model returning data = addr[7:0]. Expect 8 consecutive grants, and `disp_rvalid` on cycles N+2..N+9 with data 0x00..0x07.
- **Starvation guard:** `disp_req` held continuously, `cpu_req` read at 0x1234 raised at cycle 0. Expect `cpu_gnt` exactly at cycle 8, `disp_gnt`=0 on that cycle, and `cpu_rvalid` at cycle 10.
- **Blank priority:** both requesting, `blank`=1. Expect CPU granted first and display granted the next cycle. With `blank`=0 the display is granted first.
- **Write then read:** CPU writes 0xA5 to 0x0042, then reads 0x0042. Expect `ram_we`=1 one cycle after the write grant, no `cpu_rvalid` for the write, and `cpu_rdata`=0xA5 two cycles after the read grant.
- **Reset mid-read:** display read granted at cycle N, `rst_n` pulled low in N+1. Expect `disp_rvalid` never asserted and all `ram_*` outputs at 0 during reset.
